multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit_pkg.sv | 26 ++
 rtl/multdiv_unit_addsub_33.sv | 21 ++
 rtl/multdiv_unit.sv | 155 +++++++++++++++
 tb/tb_multdiv_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// Covers state encoding, iteration timing and the operand magnitude helper.
package multdiv_unit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int ITER_COUNT = 32;
  localparam int LATENCY    = 33;

  localparam logic [31:0] DIV_MIN_NEG = 32'h8000_0000;

  // 33-bit magnitude so that -2^31 maps to +2^31 without wrapping
  function automatic logic [32:0] magnitude(input logic [31:0] v);
    logic [32:0] ext;
    ext = {v[31], v};
    if (v[31]) begin
      magnitude = 33'd0 - ext;
    end else begin
      magnitude = ext;
    end
  endfunction

endpackage

// File: rtl/multdiv_unit_addsub_33.sv
// 33-bit adder/subtractor shared by the multiply accumulate and divide trial step.
// carry is set on subtract when no borrow occurred (a >= b).
module addsub_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        carry
);

  logic [32:0] b_eff;
  logic [33:0] total;

  always_comb begin
    b_eff = sub ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {33'd0, sub};
    sum   = total[32:0];
    carry = total[33];
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiplier / divider for the execute stage.
// A ctrl pulse starts an op; data_resultRDY pulses 33 edges later with the result.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  logic [1:0]  state;
  logic [5:0]  iter;
  logic [32:0] acc;
  logic [31:0] lo;
  logic [32:0] mag_b;
  logic        neg;
  logic        is_div;
  logic        div_zero;
  logic        div_ovf;

  logic        start_mul;
  logic        start_div;
  logic [32:0] mag_opa;
  logic [32:0] mag_opb;
  logic [32:0] add_a;
  logic [32:0] add_b;
  logic        add_sub;
  logic [32:0] add_sum;
  logic        add_carry;
  logic [32:0] mul_step;
  logic [63:0] product;
  logic [63:0] prod_signed;
  logic [31:0] quot;
  logic [31:0] fin_result;
  logic        fin_exc;

  addsub_33 u_addsub (
    .a     (add_a),
    .b     (add_b),
    .sub   (add_sub),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Launch decode: multiply wins over a simultaneous divide
  always_comb begin
    start_mul = ctrl_MULT;
    start_div = ctrl_DIV & ~ctrl_MULT;
    mag_opa   = magnitude(data_operandA);
    mag_opb   = magnitude(data_operandB);
  end

  // Adder operand steering: divide shifts the next dividend bit into the remainder
  always_comb begin
    if (state == ST_DIV) begin
      add_a   = {acc[31:0], lo[31]};
      add_b   = mag_b;
      add_sub = 1'b1;
    end else begin
      add_a   = acc;
      add_b   = mag_b;
      add_sub = 1'b0;
    end
    mul_step = lo[0] ? add_sum : acc;
  end

  // Sign correction and exception detection for the finished op
  always_comb begin
    product     = {acc[31:0], lo};
    prod_signed = neg ? (64'd0 - product) : product;
    quot        = neg ? (32'd0 - lo) : lo;
    if (is_div) begin
      if (div_zero) begin
        fin_result = 32'd0;
        fin_exc    = 1'b1;
      end else begin
        fin_result = quot;
        fin_exc    = div_ovf;
      end
    end else begin
      fin_result = prod_signed[31:0];
      fin_exc    = ~((&prod_signed[63:31]) | ~(|prod_signed[63:31]));
    end
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      iter           <= 6'd0;
      acc            <= 33'd0;
      lo             <= 32'd0;
      mag_b          <= 33'd0;
      neg            <= 1'b0;
      is_div         <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start_mul || start_div) begin
        state          <= start_mul ? ST_MULT : ST_DIV;
        iter           <= 6'd0;
        acc            <= 33'd0;
        lo             <= start_mul ? mag_opb[31:0] : mag_opa[31:0];
        mag_b          <= start_mul ? mag_opa : mag_opb;
        neg            <= data_operandA[31] ^ data_operandB[31];
        is_div         <= start_div;
        div_zero       <= (data_operandB == 32'd0);
        div_ovf        <= (data_operandA == DIV_MIN_NEG) && (data_operandB == 32'hFFFF_FFFF);
        data_result    <= 32'd0;
        data_exception <= 1'b0;
      end else begin
        case (state)
          ST_MULT: begin
            acc   <= {1'b0, mul_step[32:1]};
            lo    <= {mul_step[0], lo[31:1]};
            iter  <= iter + 6'd1;
            state <= (iter == 6'(ITER_COUNT - 1)) ? ST_DONE : ST_MULT;
          end
          ST_DIV: begin
            // carry clear means the trial subtract borrowed: keep the shifted remainder
            acc   <= add_carry ? add_sum : add_a;
            lo    <= {lo[30:0], add_carry};
            iter  <= iter + 6'd1;
            state <= (iter == 6'(ITER_COUNT - 1)) ? ST_DONE : ST_DIV;
          end
          ST_DONE: begin
            data_result    <= fin_result;
            data_exception <= fin_exc;
            data_resultRDY <= 1'b1;
            state          <= ST_IDLE;
          end
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit with hand-computed results.
module tb_multdiv_unit;
  import multdiv_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int vectors = 0;
  int miscompares = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Drive a one-cycle pulse; returns #1 after the accepting edge with inputs scrambled
  task automatic launch(input logic m, input logic d, input logic [31:0] opa, input logic [31:0] opb);
    @(negedge clock);
    data_operandA = opa;
    data_operandB = opb;
    ctrl_MULT = m;
    ctrl_DIV = d;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
  endtask

  // Watch LATENCY+7 edges after the accepting edge and report what the DUT did
  task automatic observe(output int pulses, output int at, output logic [31:0] res, output logic exc,
                         output logic [31:0] held, output logic held_exc);
    pulses = 0;
    at = -1;
    res = 32'hxxxx_xxxx;
    exc = 1'bx;
    for (int k = 1; k <= LATENCY + 7; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) begin
        pulses++;
        at = k;
        res = data_result;
        exc = data_exception;
      end
    end
    held = data_result;
    held_exc = data_exception;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({data_resultRDY, data_exception, data_result} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b exc=%b res=%h want 0 0 00000000",
               data_resultRDY, data_exception, data_result);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_ops(input logic is_div);
    logic [31:0] ta[4];
    logic [31:0] tb[4];
    logic [31:0] tr[4];
    logic        te[4];
    int n;
    int pulses, at;
    logic [31:0] res, held;
    logic exc, held_exc;
    if (is_div) begin
      ta = '{32'hFFFF_FFF9, 32'd100,      32'd5,  32'h8000_0000};
      tb = '{32'd2,         32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF};
      tr = '{32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'd0, 32'h8000_0000};
      te = '{1'b0, 1'b0, 1'b1, 1'b1};
      n = 4;
    end else begin
      ta = '{32'd7,         32'h0001_0000, 32'hFFFF_0000, 32'd0};
      tb = '{32'hFFFF_FFFA, 32'h0001_0000, 32'h0000_8000, 32'd0};
      tr = '{32'hFFFF_FFD6, 32'd0,         32'h8000_0000, 32'd0};
      te = '{1'b0, 1'b1, 1'b0, 1'b0};
      n = 3;
    end
    for (int i = 0; i < n; i++) begin
      launch(~is_div, is_div, ta[i], tb[i]);
      vectors++;
      if ({data_exception, data_result} !== 33'd0) begin
        miscompares++;
        $display("FAIL clear_on_accept[%0d]: got exc=%b res=%h want 0 00000000", i, data_exception, data_result);
      end
      observe(pulses, at, res, exc, held, held_exc);
      vectors++;
      if (pulses != 1 || at != LATENCY) begin
        miscompares++;
        $display("FAIL ready_timing[%0d]: got %0d pulses last at E0+%0d want 1 at E0+%0d", i, pulses, at, LATENCY);
      end
      vectors++;
      if (res !== tr[i] || exc !== te[i]) begin
        miscompares++;
        $display("FAIL %s_result[%0d]: got res=%h exc=%b want res=%h exc=%b",
                 is_div ? "div" : "mult", i, res, exc, tr[i], te[i]);
      end
      vectors++;
      if (held !== tr[i] || held_exc !== te[i]) begin
        miscompares++;
        $display("FAIL hold[%0d]: got res=%h exc=%b want res=%h exc=%b", i, held, held_exc, tr[i], te[i]);
      end
    end
  endtask

  task automatic test_priority();
    int pulses, at;
    logic [31:0] res, held;
    logic exc, held_exc;
    launch(1'b1, 1'b1, 32'd6, 32'd7);
    observe(pulses, at, res, exc, held, held_exc);
    vectors++;
    if (pulses != 1 || at != LATENCY || res !== 32'd42 || exc !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_priority: got pulses=%0d at=%0d res=%h exc=%b want 1 %0d 0000002a 0",
               pulses, at, res, exc, LATENCY);
    end
  endtask

  task automatic test_abort();
    int pulses, at, early;
    logic [31:0] res, held;
    logic exc, held_exc;
    launch(1'b1, 1'b0, 32'd3, 32'd4);
    early = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) early++;
    end
    launch(1'b0, 1'b1, 32'd100, 32'd7);
    if (data_resultRDY === 1'b1) early++;
    observe(pulses, at, res, exc, held, held_exc);
    vectors++;
    if (early != 0 || pulses != 1 || at != LATENCY) begin
      miscompares++;
      $display("FAIL abort_pulses: got early=%0d pulses=%0d at=%0d want 0 1 %0d", early, pulses, at, LATENCY);
    end
    vectors++;
    if (res !== 32'd14 || exc !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_result: got res=%h exc=%b want 0000000e 0", res, exc);
    end
  endtask

  task automatic test_reset_midop();
    int pulses, at;
    logic [31:0] res, held;
    logic exc, held_exc;
    launch(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010);
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({data_resultRDY, data_exception, data_result} !== 34'd0) begin
      miscompares++;
      $display("FAIL midop_reset_outputs: got rdy=%b exc=%b res=%h want 0 0 00000000",
               data_resultRDY, data_exception, data_result);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    observe(pulses, at, res, exc, held, held_exc);
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL midop_no_pulse: got %0d pulses want 0", pulses);
    end
    launch(1'b1, 1'b0, 32'd2, 32'd3);
    observe(pulses, at, res, exc, held, held_exc);
    vectors++;
    if (pulses != 1 || at != LATENCY || res !== 32'd6 || exc !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_mult: got pulses=%0d at=%0d res=%h exc=%b want 1 %0d 00000006 0",
               pulses, at, res, exc, LATENCY);
    end
  endtask

  initial begin
    test_reset();
    test_ops(1'b0);
    test_ops(1'b1);
    test_priority();
    test_abort();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
